// File: rtl/nios2_dct_capture_ctrl.sv
// nios2_dct_capture_ctrl
// Sequencer for the Nios II OCI data-capture-trace buffer. Arms on a software
// command, starts capture on a trigger and packs 2-bit trace symbols into a
// 30-bit word. Completed or partial words are handed to the trace-memory
// writer over a valid/ready handshake. The trace source is never stalled, so a
// completed word that finds the output slot busy is dropped and flagged.
//
// Optional build macro: DCT_OVF_COUNT_EN
//    When defined, an 8-bit saturating dropped-word counter is exported on
//    ovf_count. When undefined, only the sticky overflow flag is present.

module nios2_dct_capture_ctrl #(
   parameter int SYM_W  = 2,
   parameter int SYMS   = 15,
   parameter int CNT_W  = 4,
   parameter int WCNT_W = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    arm,
   input  logic                    disarm,
   input  logic                    trig,
   input  logic                    flush_req,
   input  logic                    sym_valid,
   input  logic [SYM_W-1:0]        sym_data,
   output logic [SYM_W*SYMS-1:0]   dct_buffer,
   output logic [CNT_W-1:0]        dct_count,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SYM_W*SYMS-1:0]   out_buffer,
   output logic [CNT_W-1:0]        out_count,
   output logic [1:0]              state,
   output logic                    overflow,
`ifdef DCT_OVF_COUNT_EN
   output logic [7:0]              ovf_count,
`endif
   output logic [WCNT_W-1:0]       word_cnt
);

   localparam int BUF_W = SYM_W * SYMS;

   // Encoding matches the value software reads back on the state port.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DRAIN   = 2'd3
   } dct_state_t;

   dct_state_t            r_state;
   logic [BUF_W-1:0]      r_dctBuffer;
   logic [CNT_W-1:0]      r_dctCount;
   logic                  r_outValid;
   logic [BUF_W-1:0]      r_outBuffer;
   logic [CNT_W-1:0]      r_outCount;
   logic                  r_overflow;
   logic [WCNT_W-1:0]     r_wordCnt;
`ifdef DCT_OVF_COUNT_EN
   logic [7:0]            r_ovfCount;
`endif

   logic                  w_transfer;
   logic                  w_slotFree;
   logic                  w_wordDone;
   logic                  w_drainHasData;
   logic [BUF_W-1:0]      w_shiftedBuffer;

   // Handshake and packing helpers: the slot can take a new word when it is
   // empty or when its current word is being accepted this very cycle, which
   // is what allows back-to-back words without a bubble.
   always_comb begin
      w_transfer      = r_outValid & out_ready;
      w_slotFree      = ~r_outValid | out_ready;
      w_shiftedBuffer = {r_dctBuffer[BUF_W-SYM_W-1:0], sym_data};
      w_wordDone      = sym_valid && (r_dctCount == CNT_W'(SYMS - 1));
      w_drainHasData  = (r_dctCount != '0);
   end

   // Main sequencer: state, packing buffer, output slot and status flags all
   // update together so every output is a register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_dctBuffer <= '0;
         r_dctCount  <= '0;
         r_outValid  <= 1'b0;
         r_outBuffer <= '0;
         r_outCount  <= '0;
         r_overflow  <= 1'b0;
         r_wordCnt   <= '0;
`ifdef DCT_OVF_COUNT_EN
         r_ovfCount  <= 8'd0;
`endif
      end else begin
         if (w_transfer) begin
            r_outValid <= 1'b0;
            r_wordCnt  <= r_wordCnt + 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (arm && !disarm) begin
                  r_state    <= ARMED;
                  r_overflow <= 1'b0;
`ifdef DCT_OVF_COUNT_EN
                  r_ovfCount <= 8'd0;
`endif
               end
            end

            ARMED: begin
               if (disarm) begin
                  r_state <= IDLE;
               end else if (trig) begin
                  r_state     <= CAPTURE;
                  r_dctBuffer <= '0;
                  r_dctCount  <= '0;
               end
            end

            CAPTURE: begin
               if (w_wordDone) begin
                  if (w_slotFree) begin
                     r_outValid  <= 1'b1;
                     r_outBuffer <= w_shiftedBuffer;
                     r_outCount  <= CNT_W'(SYMS);
                  end else begin
                     r_overflow <= 1'b1;
`ifdef DCT_OVF_COUNT_EN
                     if (r_ovfCount != 8'hFF) begin
                        r_ovfCount <= r_ovfCount + 8'd1;
                     end
`endif
                  end
                  r_dctBuffer <= '0;
                  r_dctCount  <= '0;
               end else if (sym_valid) begin
                  r_dctBuffer <= w_shiftedBuffer;
                  r_dctCount  <= r_dctCount + 1'b1;
               end
               if (disarm || flush_req) begin
                  r_state <= DRAIN;
               end
            end

            DRAIN: begin
               if (!w_drainHasData) begin
                  r_state <= IDLE;
               end else if (w_slotFree) begin
                  r_outValid  <= 1'b1;
                  r_outBuffer <= r_dctBuffer;
                  r_outCount  <= r_dctCount;
                  r_dctBuffer <= '0;
                  r_dctCount  <= '0;
                  r_state     <= IDLE;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign dct_buffer = r_dctBuffer;
   assign dct_count  = r_dctCount;
   assign out_valid  = r_outValid;
   assign out_buffer = r_outBuffer;
   assign out_count  = r_outCount;
   assign state      = r_state;
   assign overflow   = r_overflow;
   assign word_cnt   = r_wordCnt;
`ifdef DCT_OVF_COUNT_EN
   assign ovf_count  = r_ovfCount;
`endif

endmodule

// File: tb/tb_nios2_dct_capture_ctrl.sv
// tb_nios2_dct_capture_ctrl
// Directed bench for the DCT capture sequencer. A queue-based reference model
// tracks the captured symbols and the pending output word; outputs are
// compared to it every cycle. A second instance with a 4-bit word counter
// shares all inputs so the counter wrap is reachable in a short run.

`timescale 1ns/1ps

module tb_nios2_dct_capture_ctrl;

   logic        clk;
   logic        reset_n;
   logic        arm;
   logic        disarm;
   logic        trig;
   logic        flush_req;
   logic        sym_valid;
   logic [1:0]  sym_data;
   logic        out_ready;

   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        out_valid;
   logic [29:0] out_buffer;
   logic [3:0]  out_count;
   logic [1:0]  state;
   logic        overflow;
   logic [15:0] word_cnt;

   logic [29:0] dct_buffer2;
   logic [3:0]  dct_count2;
   logic        out_valid2;
   logic [29:0] out_buffer2;
   logic [3:0]  out_count2;
   logic [1:0]  state2;
   logic        overflow2;
   logic [3:0]  word_cnt2;

`ifdef DCT_OVF_COUNT_EN
   logic [7:0]  ovf_count;
   logic [7:0]  ovf_count2;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state
   int          mState = 0;
   int          mSyms[$];
   bit          mOutValid = 0;
   logic [29:0] mOutBuf = '0;
   int          mOutCount = 0;
   bit          mOverflow = 0;
   int          mOvfCount = 0;
   int          mWordCnt = 0;

   nios2_dct_capture_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .arm        (arm),
      .disarm     (disarm),
      .trig       (trig),
      .flush_req  (flush_req),
      .sym_valid  (sym_valid),
      .sym_data   (sym_data),
      .dct_buffer (dct_buffer),
      .dct_count  (dct_count),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_buffer (out_buffer),
      .out_count  (out_count),
      .state      (state),
      .overflow   (overflow),
`ifdef DCT_OVF_COUNT_EN
      .ovf_count  (ovf_count),
`endif
      .word_cnt   (word_cnt)
   );

   nios2_dct_capture_ctrl #(.WCNT_W(4)) dutWrap (
      .clk        (clk),
      .reset_n    (reset_n),
      .arm        (arm),
      .disarm     (disarm),
      .trig       (trig),
      .flush_req  (flush_req),
      .sym_valid  (sym_valid),
      .sym_data   (sym_data),
      .dct_buffer (dct_buffer2),
      .dct_count  (dct_count2),
      .out_valid  (out_valid2),
      .out_ready  (out_ready),
      .out_buffer (out_buffer2),
      .out_count  (out_count2),
      .state      (state2),
      .overflow   (overflow2),
`ifdef DCT_OVF_COUNT_EN
      .ovf_count  (ovf_count2),
`endif
      .word_cnt   (word_cnt2)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: count it, and report it when the values differ
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Packed value of the symbols held, oldest symbol in the most significant position
   function automatic logic [29:0] packSyms(input int syms[$]);
      logic [31:0] v;
      v = 0;
      foreach (syms[i]) v = v * 4 + syms[i];
      return v[29:0];
   endfunction

   // Advance the model by one rising edge using the inputs present before it
   task automatic modelStep();
      bit slotFree;
      if (!reset_n) begin
         mState = 0; mSyms.delete(); mOutValid = 0; mOutBuf = '0;
         mOutCount = 0; mOverflow = 0; mOvfCount = 0; mWordCnt = 0;
         return;
      end
      slotFree = !mOutValid || out_ready;
      if (mOutValid && out_ready) begin
         mWordCnt  = (mWordCnt + 1) % 65536;
         mOutValid = 0;
      end
      case (mState)
         0: if (arm && !disarm) begin
               mState = 1; mOverflow = 0; mOvfCount = 0;
            end
         1: if (disarm) mState = 0;
            else if (trig) begin
               mState = 2; mSyms.delete();
            end
         2: begin
               if (sym_valid) begin
                  mSyms.push_back(int'(sym_data));
                  if (mSyms.size() == 15) begin
                     if (slotFree) begin
                        mOutValid = 1; mOutBuf = packSyms(mSyms); mOutCount = 15;
                     end else begin
                        mOverflow = 1;
                        if (mOvfCount < 255) mOvfCount++;
                     end
                     mSyms.delete();
                  end
               end
               if (disarm || flush_req) mState = 3;
            end
         default: begin
               if (mSyms.size() == 0) mState = 0;
               else if (slotFree) begin
                  mOutValid = 1; mOutBuf = packSyms(mSyms); mOutCount = mSyms.size();
                  mSyms.delete();
                  mState = 0;
               end
            end
      endcase
   endtask

   // Model follows every rising edge
   initial begin
      forever begin
         @(posedge clk);
         modelStep();
      end
   end

   // Compare both instances against the model on every falling edge
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         checkOutput("state",      32'(state),      32'(mState));
         checkOutput("dct_count",  32'(dct_count),  32'(mSyms.size()));
         checkOutput("dct_buffer", 32'(dct_buffer), 32'(packSyms(mSyms)));
         checkOutput("out_valid",  32'(out_valid),  32'(mOutValid));
         checkOutput("out_buffer", 32'(out_buffer), 32'(mOutBuf));
         checkOutput("out_count",  32'(out_count),  32'(mOutCount));
         checkOutput("overflow",   32'(overflow),   32'(mOverflow));
         checkOutput("word_cnt",   32'(word_cnt),   32'(mWordCnt));
         checkOutput("w2_state",     32'(state2),      32'(mState));
         checkOutput("w2_dct_count", 32'(dct_count2),  32'(mSyms.size()));
         checkOutput("w2_dct_buf",   32'(dct_buffer2), 32'(packSyms(mSyms)));
         checkOutput("w2_out_valid", 32'(out_valid2),  32'(mOutValid));
         checkOutput("w2_out_buf",   32'(out_buffer2), 32'(mOutBuf));
         checkOutput("w2_out_count", 32'(out_count2),  32'(mOutCount));
         checkOutput("w2_overflow",  32'(overflow2),   32'(mOverflow));
         checkOutput("w2_word_cnt",  32'(word_cnt2),   32'(mWordCnt % 16));
`ifdef DCT_OVF_COUNT_EN
         checkOutput("ovf_count",    32'(ovf_count),   32'(mOvfCount));
         checkOutput("w2_ovf_count", 32'(ovf_count2),  32'(mOvfCount));
`endif
      end
   end

   // Drive one cycle of inputs; outputs seen on return reflect the previous call
   task automatic applyStimulus(input logic a, input logic d, input logic t,
                                input logic f, input logic sv, input logic [1:0] sd);
      @(negedge clk);
      arm = a; disarm = d; trig = t; flush_req = f; sym_valid = sv; sym_data = sd;
   endtask

   task automatic idleCycle();
      applyStimulus(0, 0, 0, 0, 0, 2'd0);
   endtask

   task automatic applyReset();
      @(negedge clk);
      arm = 0; disarm = 0; trig = 0; flush_req = 0; sym_valid = 0; sym_data = 0;
      reset_n = 0;
      @(negedge clk);
      reset_n = 1;
   endtask

   // Guard against a hung run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios with hand-computed expectations
   initial begin
      reset_n = 0; arm = 0; disarm = 0; trig = 0; flush_req = 0;
      sym_valid = 0; sym_data = 0; out_ready = 0;

      applyReset();
      checkOutput("rst_state",    32'(state),      32'd0);
      checkOutput("rst_dct_buf",  32'(dct_buffer), 32'd0);
      checkOutput("rst_out_val",  32'(out_valid),  32'd0);
      checkOutput("rst_word_cnt", 32'(word_cnt),   32'd0);

      // Full word with pattern 1,2,3; a symbol in the trig cycle is ignored
      $display("[TB] full word");
      out_ready = 1;
      applyStimulus(1, 0, 0, 0, 0, 2'd0);
      applyStimulus(0, 0, 1, 0, 1, 2'd3);
      for (int i = 0; i < 15; i++) begin
         applyStimulus(0, 0, 0, 0, 1, 2'((i % 3) + 1));
         if (i == 0) checkOutput("trig_sym_ignored", 32'(dct_count), 32'd0);
      end
      idleCycle();
      checkOutput("full_out_valid", 32'(out_valid),  32'd1);
      checkOutput("full_out_buf",   32'(out_buffer), 32'h1B6DB6DB);
      checkOutput("full_out_count", 32'(out_count),  32'd15);
      checkOutput("full_dct_count", 32'(dct_count),  32'd0);
      idleCycle();
      checkOutput("full_word_cnt",  32'(word_cnt),   32'd1);

      // Partial flush of five 2'b11 symbols
      $display("[TB] partial flush");
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1, 2'd3);
      applyStimulus(0, 0, 0, 1, 0, 2'd0);
      idleCycle();
      checkOutput("flush_drain_state", 32'(state), 32'd3);
      idleCycle();
      checkOutput("flush_out_buf",   32'(out_buffer), 32'h000003FF);
      checkOutput("flush_out_count", 32'(out_count),  32'd5);
      checkOutput("flush_idle",      32'(state),      32'd0);
      idleCycle();
      checkOutput("flush_word_cnt",  32'(word_cnt),   32'd2);

      // Overflow: writer stalled across two full words
      $display("[TB] overflow");
      out_ready = 0;
      applyStimulus(1, 0, 0, 0, 0, 2'd0);
      applyStimulus(0, 0, 1, 0, 0, 2'd0);
      for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 0, 1, 2'd2);
      for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 0, 1, 2'd1);
      idleCycle();
      checkOutput("ovf_flag",      32'(overflow),   32'd1);
      checkOutput("ovf_held_buf",  32'(out_buffer), 32'h2AAAAAAA);
      checkOutput("ovf_held_val",  32'(out_valid),  32'd1);
      checkOutput("ovf_word_cnt",  32'(word_cnt),   32'd2);
`ifdef DCT_OVF_COUNT_EN
      checkOutput("ovf_count_one", 32'(ovf_count),  32'd1);
`endif
      out_ready = 1;
      idleCycle();
      checkOutput("ovf_drained_cnt", 32'(word_cnt), 32'd3);
      applyStimulus(0, 0, 0, 1, 0, 2'd0);
      idleCycle();
      idleCycle();
      checkOutput("empty_drain_idle", 32'(state),     32'd0);
      checkOutput("empty_drain_nov",  32'(out_valid), 32'd0);

      // Simultaneous events
      $display("[TB] simultaneous events");
      applyStimulus(1, 1, 0, 0, 0, 2'd0);
      idleCycle();
      checkOutput("arm_disarm_idle",  32'(state),    32'd0);
      checkOutput("ovf_kept_sticky",  32'(overflow), 32'd1);
      applyStimulus(1, 0, 0, 0, 0, 2'd0);
      applyStimulus(0, 0, 1, 0, 0, 2'd0);
      checkOutput("arm_state",        32'(state),    32'd1);
      checkOutput("arm_clears_ovf",   32'(overflow), 32'd0);
      applyStimulus(0, 0, 0, 0, 1, 2'd1);
      applyStimulus(0, 0, 0, 0, 1, 2'd2);
      applyStimulus(0, 0, 0, 0, 1, 2'd3);
      applyStimulus(0, 1, 0, 0, 1, 2'd0);
      idleCycle();
      checkOutput("disarm_sym_count", 32'(dct_count), 32'd4);
      idleCycle();
      checkOutput("disarm_out_buf",   32'(out_buffer), 32'h6C);
      checkOutput("disarm_out_count", 32'(out_count),  32'd4);
      idleCycle();
      checkOutput("disarm_word_cnt",  32'(word_cnt),   32'd4);

      // Reset during capture
      $display("[TB] reset mid-capture");
      applyStimulus(1, 0, 0, 0, 0, 2'd0);
      applyStimulus(0, 0, 1, 0, 0, 2'd0);
      for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, 1, 2'd2);
      applyReset();
      checkOutput("mid_rst_count",   32'(dct_count),  32'd0);
      checkOutput("mid_rst_buf",     32'(dct_buffer), 32'd0);
      checkOutput("mid_rst_out_buf", 32'(out_buffer), 32'd0);
      checkOutput("mid_rst_state",   32'(state),      32'd0);
      checkOutput("mid_rst_wcnt",    32'(word_cnt),   32'd0);
      for (int i = 0; i < 3; i++) idleCycle();
      checkOutput("mid_rst_no_pulse", 32'(out_valid), 32'd0);

      // Back-to-back load and word counter wrap on the narrow instance
      $display("[TB] back-to-back and wrap");
      out_ready = 0;
      applyStimulus(1, 0, 0, 0, 0, 2'd0);
      applyStimulus(0, 0, 1, 0, 0, 2'd0);
      for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 0, 1, 2'(i % 4));
      for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 0, 1, 2'd3);
      out_ready = 1;
      idleCycle();
      checkOutput("b2b_valid",    32'(out_valid),  32'd1);
      checkOutput("b2b_out_buf",  32'(out_buffer), 32'h3FFFFFFF);
      checkOutput("b2b_word_cnt", 32'(word_cnt),   32'd1);
      checkOutput("b2b_no_ovf",   32'(overflow),   32'd0);
      for (int w = 0; w < 15; w++)
         for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 0, 1, 2'((w + i) % 4));
      idleCycle();
      idleCycle();
      checkOutput("wrap_wide_cnt",   32'(word_cnt),  32'd17);
      checkOutput("wrap_narrow_cnt", 32'(word_cnt2), 32'd1);

`ifdef DCT_OVF_COUNT_EN
      // Dropped-word counter saturates
      $display("[TB] ovf_count saturation");
      applyStimulus(0, 0, 0, 1, 0, 2'd0);
      idleCycle();
      idleCycle();
      out_ready = 0;
      applyStimulus(1, 0, 0, 0, 0, 2'd0);
      applyStimulus(0, 0, 1, 0, 0, 2'd0);
      for (int i = 0; i < 15 * 258; i++) applyStimulus(0, 0, 0, 0, 1, 2'd1);
      idleCycle();
      checkOutput("ovf_count_sat", 32'(ovf_count), 32'd255);
`endif

      idleCycle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
